// File: rtl/hilo_div_ctrl_pkg.sv
// Shared definitions for the HI/LO divide controller: operand width, divider latency,
// FSM encoding and the operand bundle handed to the iterative divider.
package hilo_div_ctrl_pkg;

  localparam int XLEN       = 32;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rt;
  } opnd_t;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which is the correct unsigned value.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_div_ctrl_div.sv
// Signed restoring divider: one quotient bit per clock, DIV_CYCLES clocks after start_i.
// Quotient truncates toward zero, remainder carries the dividend's sign.
module hilo_div_ctrl_div
  import hilo_div_ctrl_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic            busy_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q;
  logic             neg_quo_q, neg_rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    trial, diff;

  // quo_q starts as the dividend magnitude and shifts quotient bits in from the right.
  always_comb begin
    trial = {rem_q, quo_q[XLEN-1]};
    diff  = trial - {1'b0, dvs_q};
    rem_d = trial[XLEN-1:0];
    quo_d = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_d = diff[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
    end else if (start_i) begin
      rem_q     <= '0;
      quo_q     <= mag(dvd_i);
      dvs_q     <= mag(dvs_i);
      neg_quo_q <= dvd_i[XLEN-1] ^ dvs_i[XLEN-1];
      neg_rem_q <= dvd_i[XLEN-1];
      cnt_q     <= CNT_W'(DIV_CYCLES);
    end else if (busy_o) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy_o = (cnt_q != '0);
  assign quo_o  = neg_quo_q ? -quo_q : quo_q;
  assign rem_o  = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register file with a stalling signed DIV sequencer (IDLE/START/WAIT/DRAIN).
// Define HILO_DIV0_TRAP_EN to trap divide-by-zero on div0_exc instead of running the divider.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            div_req,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            mthi_we,
  input  logic            mtlo_we,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            stall
`ifdef HILO_DIV0_TRAP_EN
  ,
  output logic            div0_exc
`endif
);

  state_e          state_q;
  opnd_t           opnd_q;
  logic [XLEN-1:0] hi_q, lo_q;

  logic            div_rst, div_start, div_busy, div_go;
  logic [XLEN-1:0] div_quo, div_rem;

`ifdef HILO_DIV0_TRAP_EN
  logic div_zero, div0_q;
  assign div_zero = div_req && (rt_val == '0);
  assign div_go   = div_req && !div_zero;
  assign div0_exc = div0_q;
`else
  assign div_go   = div_req;
`endif

  assign div_rst   = ~reset;
  assign div_start = (state_q == ST_START) && !flush;

  // In DRAIN any request must wait for the abandoned division to finish, so raw div_req stalls.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE:           stall = div_go;
      ST_START, ST_WAIT: stall = 1'b1;
      ST_DRAIN:          stall = div_req;
      default:           stall = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef HILO_DIV0_TRAP_EN
      div0_q  <= 1'b0;
`endif
    end else begin
`ifdef HILO_DIV0_TRAP_EN
      div0_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (div_go) begin
            opnd_q.rs <= rs_val;
            opnd_q.rt <= rt_val;
            state_q   <= ST_START;
          end
`ifdef HILO_DIV0_TRAP_EN
          else if (div_zero) begin
            div0_q <= 1'b1;
          end
`endif
          else begin
            if (mthi_we) hi_q <= wdata;
            if (mtlo_we) lo_q <= wdata;
          end
        end
        ST_START: begin
          state_q <= flush ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (flush) begin
            state_q <= ST_DRAIN;
          end else if (!div_busy) begin
            lo_q    <= div_quo;
            hi_q    <= div_rem;
            state_q <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!div_busy) begin
            state_q <= ST_IDLE;
            if (div_go) begin
              opnd_q.rs <= rs_val;
              opnd_q.rt <= rt_val;
              state_q   <= ST_START;
            end
`ifdef HILO_DIV0_TRAP_EN
            else if (div_zero) begin
              div0_q <= 1'b1;
            end
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  hilo_div_ctrl_div DIV (
    .clk_i   (clock),
    .rst_i   (div_rst),
    .start_i (div_start),
    .dvd_i   (opnd_q.rs),
    .dvs_i   (opnd_q.rt),
    .busy_o  (div_busy),
    .quo_o   (div_quo),
    .rem_o   (div_rem)
  );

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: vector table plus hand-written flush, reset and MT sequences.
module tb_hilo_div_ctrl;

  logic        clock, reset, div_req, mthi_we, mtlo_we, flush;
  logic [31:0] rs_val, rt_val, wdata, hi, lo;
  logic        stall;
`ifdef HILO_DIV0_TRAP_EN
  logic        div0_exc;
`endif

  hilo_div_ctrl dut (
    .clock   (clock),
    .reset   (reset),
    .div_req (div_req),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .wdata   (wdata),
    .flush   (flush),
    .hi      (hi),
    .lo      (lo),
    .stall   (stall)
`ifdef HILO_DIV0_TRAP_EN
    ,
    .div0_exc(div0_exc)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    string       nm;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    string       nm;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   checks   = 0;
  int   failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Issues one DIV in the current cycle, counts stall cycles, then scores the result.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input string nm, input bit chk_res, input int mt_cyc);
    int          cyc, scnt;
    logic [31:0] lo_prev;
    exp_t        e;
    lo_prev = lo;
    if (chk_res) sb.push_back('{lo: elo, hi: ehi, nm: nm});
    div_req = 1'b1; rs_val = a; rt_val = b;
    #1;
    cyc = 0; scnt = 0;
    while (stall && scnt < 100) begin
      scnt++;
      tick();
      cyc++;
      div_req = 1'b0;
      mtlo_we = (cyc == mt_cyc);
      wdata   = 32'hDEADBEEF;
      #1;
      if (mt_cyc > 0 && cyc == mt_cyc + 1) chk({nm, "_mtlo_ignored"}, lo, lo_prev);
    end
    mtlo_we = 1'b0;
    chk({nm, "_stall_cycles"}, 32'(scnt), 32'd35);
    if (chk_res) begin
      e = sb.pop_front();
      chk({e.nm, "_lo"}, lo, e.lo);
      chk({e.nm, "_hi"}, hi, e.hi);
    end
  endtask

  initial begin
    int          scnt, cyc;
    logic [31:0] hp, lp, ra, rb, elo, ehi;
    longint      la, lb, lq, lr;
    exp_t        e;

    tbl[0] = '{32'd100,        32'd7,        32'h0000000E, 32'h00000002, "div_100_7"};
    tbl[1] = '{32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, "div_m100_7"};
    tbl[2] = '{32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, "div_min_m1"};
    tbl[3] = '{32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, "div_7_m2"};
    tbl[4] = '{32'hFFFFFFF9,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, "div_m7_m2"};
    tbl[5] = '{32'd0,          32'd5,        32'h00000000, 32'h00000000, "div_0_5"};
    tbl[6] = '{32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 32'h00000000, "div_max_1"};
    tbl[7] = '{32'd5,          32'h80000000, 32'h00000000, 32'h00000005, "div_5_min"};

    reset = 1'b1; div_req = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; flush = 1'b0;
    rs_val = '0; rt_val = '0; wdata = '0;
    #1 reset = 1'b0;
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);
`ifdef HILO_DIV0_TRAP_EN
    chk("reset_div0_exc", 32'(div0_exc), 32'h0);
`endif
    tick(); tick();
    reset = 1'b1;
    run_div(32'd100, 32'd7, 32'h0000000E, 32'h00000002, "first_after_reset", 1'b1, -1);

    for (int i = 0; i < 8; i++) begin
      tick();
      run_div(tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, tbl[i].nm, 1'b1, -1);
    end

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
      if (rb == 32'h0) rb = 32'd3;
      if (i == 2) rb = -rb;
      la = longint'($signed(ra));
      lb = longint'($signed(rb));
      lq = la / lb;
      lr = la % lb;
      elo = lq[31:0];
      ehi = lr[31:0];
      tick();
      run_div(ra, rb, elo, ehi, "div_random", 1'b1, -1);
    end

    // MTHI then MTLO in IDLE
    tick();
    hp = hi;
    mthi_we = 1'b1; wdata = 32'h12345678;
    #1;
    chk("mthi_before_edge", hi, hp);
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'hCAFEBABE;
    #1;
    chk("mthi_hi", hi, 32'h12345678);
    tick();
    mtlo_we = 1'b0;
    #1;
    chk("mtlo_lo", lo, 32'hCAFEBABE);
    chk("mtlo_hi_kept", hi, 32'h12345678);

    tick();
    run_div(32'd100, 32'd7, 32'h0000000E, 32'h00000002, "div_mtlo_wait", 1'b1, 10);

    // Preload distinctive HI/LO, then flush a DIV in cycle 10 and queue one in cycle 12
    tick(); mthi_we = 1'b1; wdata = 32'hA5A5A5A5;
    tick(); mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h5A5A5A5A;
    tick(); mtlo_we = 1'b0;
    #1;
    hp = hi; lp = lo;
    chk("preload_hi", hp, 32'hA5A5A5A5);
    tick();
    div_req = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    #1;
    chk("flush_c0_stall", 32'(stall), 32'h1);
    for (int c = 1; c <= 10; c++) begin
      tick();
      div_req = 1'b0;
      flush = (c == 10);
      #1;
    end
    chk("flush_c10_stall", 32'(stall), 32'h1);
    tick(); flush = 1'b0; #1;
    chk("flush_c11_stall", 32'(stall), 32'h0);
    tick();
    div_req = 1'b1; rs_val = 32'd1024; rt_val = 32'd3;
    sb.push_back('{lo: 32'h00000155, hi: 32'h00000001, nm: "div_after_drain"});
    #1;
    scnt = 0; cyc = 12;
    while (stall && scnt < 200) begin
      scnt++;
      tick();
      cyc++;
      if (cyc == 35) div_req = 1'b0;
      #1;
      if (cyc == 35) begin
        chk("drain_hi_unchanged", hi, hp);
        chk("drain_lo_unchanged", lo, lp);
      end
    end
    chk("drain_stall_cycles", 32'(scnt), 32'd57);
    e = sb.pop_front();
    chk({e.nm, "_lo"}, lo, e.lo);
    chk({e.nm, "_hi"}, hi, e.hi);

    // Reset in cycle 20 of a DIV
    tick();
    div_req = 1'b1; rs_val = 32'd100; rt_val = 32'd7;
    #1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      div_req = 1'b0;
      #1;
    end
    reset = 1'b0;
    #1;
    chk("midreset_hi", hi, 32'h0);
    chk("midreset_lo", lo, 32'h0);
    chk("midreset_stall", 32'(stall), 32'h0);
    tick();
    reset = 1'b1;
    run_div(32'd9, 32'd2, 32'h00000004, 32'h00000001, "div_9_2_after_reset", 1'b1, -1);

`ifdef HILO_DIV0_TRAP_EN
    tick();
    hp = hi; lp = lo;
    div_req = 1'b1; rs_val = 32'd5; rt_val = 32'd0;
    #1;
    chk("div0_c0_stall", 32'(stall), 32'h0);
    chk("div0_c0_exc", 32'(div0_exc), 32'h0);
    tick(); div_req = 1'b0; #1;
    chk("div0_c1_exc", 32'(div0_exc), 32'h1);
    chk("div0_c1_stall", 32'(stall), 32'h0);
    tick(); #1;
    chk("div0_c2_exc", 32'(div0_exc), 32'h0);
    chk("div0_hi_kept", hi, hp);
    chk("div0_lo_kept", lo, lp);
`else
    tick();
    run_div(32'd5, 32'd0, 32'h0, 32'h0, "div_by_zero_runs", 1'b0, -1);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
